// File: rtl/wb_arb_pkg.sv
// Shared types for the SDRAM Wishbone arbiter: FSM states and one-hot grant encoding.
// The ABORT state exists only when WB_ARB_TIMEOUT_EN is defined.
package wb_arb_pkg;

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DMA = 2'd2,
        ABORT   = 2'd3
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_DMA = 2'd2
    } arb_state_e;
`endif

    // One-hot owner, bit 1 = DMA, bit 0 = CPU.
    typedef logic [1:0] grant_t;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_CPU  = 2'b01;
    localparam grant_t GRANT_DMA  = 2'b10;

endpackage

// File: rtl/wishbone_b3.sv
// Wishbone B3 bus bundle with master/slave views; dat_w flows master->slave, dat_r slave->master.
interface wishbone_b3 #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_sdram_arbiter.sv
// Two-master (CPU, screen DMA) arbiter in front of a single SDRAM Wishbone port.
// Define WB_ARB_TIMEOUT_EN to add the ack wait counter and the one-cycle ABORT state.
module wb_sdram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT   = 1024,
    parameter bit DMA_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    wishbone_b3.slave  cpu_bus,
    wishbone_b3.slave  dma_bus,
    wishbone_b3.master sdr_bus,
    input  logic       dma_urgent,
    output grant_t     grant
);

    if (TIMEOUT < 16 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_sdram_arbiter: TIMEOUT must be within 16..65535");
    end

    arb_state_e state_q, state_d;
    grant_t     grant_q, grant_d;
    logic       prio_dma_q, prio_dma_d;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] wait_q, wait_d;
    logic        granted;
    logic        timeout_hit;

    // Counter only runs while a master owns the bus; an ack always rescues the tenure.
    always_comb begin
        granted     = (state_q == GNT_CPU) || (state_q == GNT_DMA);
        wait_d      = wait_q;
        timeout_hit = 1'b0;
        if (!granted || sdr_bus.ack) begin
            wait_d = '0;
        end else begin
            timeout_hit = (wait_q == WAIT_LIMIT);
            if (sdr_bus.stb && wait_q != 16'hFFFF) begin
                wait_d = wait_q + 16'd1;
            end
        end
    end
`endif

    always_comb begin
        sdr_bus.adr   = '0;
        sdr_bus.dat_w = '0;
        sdr_bus.sel   = '0;
        sdr_bus.we    = 1'b0;
        sdr_bus.cyc   = 1'b0;
        sdr_bus.stb   = 1'b0;
        sdr_bus.cti   = '0;
        sdr_bus.bte   = '0;
        cpu_bus.ack   = 1'b0;
        cpu_bus.err   = 1'b0;
        cpu_bus.dat_r = sdr_bus.dat_r;
        dma_bus.ack   = 1'b0;
        dma_bus.err   = 1'b0;
        dma_bus.dat_r = sdr_bus.dat_r;
        case (state_q)
            GNT_CPU: begin
                sdr_bus.adr   = cpu_bus.adr;
                sdr_bus.dat_w = cpu_bus.dat_w;
                sdr_bus.sel   = cpu_bus.sel;
                sdr_bus.we    = cpu_bus.we;
                sdr_bus.cyc   = cpu_bus.cyc;
                sdr_bus.stb   = cpu_bus.stb;
                sdr_bus.cti   = cpu_bus.cti;
                sdr_bus.bte   = cpu_bus.bte;
                cpu_bus.ack   = sdr_bus.ack;
                cpu_bus.err   = sdr_bus.err;
            end
            GNT_DMA: begin
                sdr_bus.adr   = dma_bus.adr;
                sdr_bus.dat_w = dma_bus.dat_w;
                sdr_bus.sel   = dma_bus.sel;
                sdr_bus.we    = dma_bus.we;
                sdr_bus.cyc   = dma_bus.cyc;
                sdr_bus.stb   = dma_bus.stb;
                sdr_bus.cti   = dma_bus.cti;
                sdr_bus.bte   = dma_bus.bte;
                dma_bus.ack   = sdr_bus.ack;
                dma_bus.err   = sdr_bus.err;
            end
`ifdef WB_ARB_TIMEOUT_EN
            // grant_q still names the aborted owner during this cycle.
            ABORT: begin
                cpu_bus.err = (grant_q == GRANT_CPU);
                dma_bus.err = (grant_q == GRANT_DMA);
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        prio_dma_d = prio_dma_q;
        case (state_q)
            IDLE: begin
                if (cpu_bus.cyc && dma_bus.cyc) begin
                    state_d = (dma_urgent || prio_dma_q) ? GNT_DMA : GNT_CPU;
                end else if (dma_bus.cyc) begin
                    state_d = GNT_DMA;
                end else if (cpu_bus.cyc) begin
                    state_d = GNT_CPU;
                end
                if (state_d == GNT_DMA) begin
                    prio_dma_d = 1'b0;
                end else if (state_d == GNT_CPU) begin
                    prio_dma_d = 1'b1;
                end
            end
            GNT_CPU: begin
                if (!cpu_bus.cyc) begin
                    state_d = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = ABORT;
`endif
                end
            end
            GNT_DMA: begin
                if (!dma_bus.cyc) begin
                    state_d = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = ABORT;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            GNT_CPU: grant_d = GRANT_CPU;
            GNT_DMA: grant_d = GRANT_DMA;
`ifdef WB_ARB_TIMEOUT_EN
            ABORT:   grant_d = grant_q;
`endif
            default: grant_d = GRANT_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_NONE;
            prio_dma_q <= DMA_FIRST;
`ifdef WB_ARB_TIMEOUT_EN
            wait_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            prio_dma_q <= prio_dma_d;
`ifdef WB_ARB_TIMEOUT_EN
            wait_q     <= wait_d;
`endif
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: directed scenarios plus randomized masters and slave,
// checked every cycle against a transaction-level ownership model (timeout parts under WB_ARB_TIMEOUT_EN).
module tb_wb_sdram_arbiter;
    import wb_arb_pkg::*;

    localparam int TIMEOUT = 16;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   dma_urgent = 1'b0;
    grant_t grant;

    wishbone_b3 cpu_if ();
    wishbone_b3 dma_if ();
    wishbone_b3 sdr_if ();

    // Index 0 = CPU, 1 = DMA.
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic [2:0]  m_cti [2];
    logic        a_ack [2];
    logic        a_err [2];
    logic [31:0] a_dat [2];

    logic        slave_ready = 1'b0;
    logic        slave_err   = 1'b0;
    logic [31:0] slave_dat   = 32'h0;

    int  tests = 0;
    int  fails = 0;
    bit  check_en = 1'b0;

    always #5 clk = ~clk;

    assign cpu_if.cyc = m_cyc[0];  assign dma_if.cyc = m_cyc[1];
    assign cpu_if.stb = m_stb[0];  assign dma_if.stb = m_stb[1];
    assign cpu_if.we  = m_we[0];   assign dma_if.we  = m_we[1];
    assign cpu_if.adr = m_adr[0];  assign dma_if.adr = m_adr[1];
    assign cpu_if.dat_w = m_dat[0]; assign dma_if.dat_w = m_dat[1];
    assign cpu_if.sel = m_sel[0];  assign dma_if.sel = m_sel[1];
    assign cpu_if.cti = m_cti[0];  assign dma_if.cti = m_cti[1];
    assign cpu_if.bte = 2'b00;     assign dma_if.bte = 2'b00;
    assign a_ack[0] = cpu_if.ack;  assign a_ack[1] = dma_if.ack;
    assign a_err[0] = cpu_if.err;  assign a_err[1] = dma_if.err;
    assign a_dat[0] = cpu_if.dat_r; assign a_dat[1] = dma_if.dat_r;

    assign sdr_if.ack   = sdr_if.cyc & sdr_if.stb & slave_ready & ~slave_err;
    assign sdr_if.err   = sdr_if.cyc & sdr_if.stb & slave_err;
    assign sdr_if.dat_r = slave_dat;

    wb_sdram_arbiter #(
        .TIMEOUT   (TIMEOUT),
        .DMA_FIRST (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_bus    (cpu_if),
        .dma_bus    (dma_if),
        .sdr_bus    (sdr_if),
        .dma_urgent (dma_urgent),
        .grant      (grant)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the SDRAM port, derived from the arbitration rules.
    // owner 0 = nobody, 1 = CPU, 2 = DMA.
    // ------------------------------------------------------------------
    int   exp_owner    = 0;
    bit   exp_abort    = 1'b0;
    bit   exp_prio_dma = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
    int   exp_wait     = 0;
`endif
    bit   live;
    int   mi;
    int   winner;
    logic e_cyc, e_stb, s_ack, s_err, e_ack, e_err;
    logic [1:0] e_grant;

    initial begin
        forever begin
            @(negedge clk);
            live    = (exp_owner != 0) && !exp_abort;
            mi      = (exp_owner == 2) ? 1 : 0;
            e_cyc   = live ? m_cyc[mi] : 1'b0;
            e_stb   = live ? m_stb[mi] : 1'b0;
            s_ack   = e_cyc & e_stb & slave_ready & ~slave_err;
            s_err   = e_cyc & e_stb & slave_err;
            e_grant = (exp_owner == 1) ? 2'b01 : (exp_owner == 2) ? 2'b10 : 2'b00;
            if (check_en) begin
                check_output("grant", 32'(grant), 32'(e_grant));
                check_output("sdr_cyc", 32'(sdr_if.cyc), 32'(e_cyc));
                check_output("sdr_stb", 32'(sdr_if.stb), 32'(e_stb));
                for (int m = 0; m < 2; m++) begin
                    e_ack = (live && exp_owner == m + 1) ? s_ack : 1'b0;
                    e_err = (exp_owner == m + 1) ? (exp_abort ? 1'b1 : s_err) : 1'b0;
                    check_output(m == 0 ? "cpu_ack" : "dma_ack", 32'(a_ack[m]), 32'(e_ack));
                    check_output(m == 0 ? "cpu_err" : "dma_err", 32'(a_err[m]), 32'(e_err));
                    check_output(m == 0 ? "cpu_dat_r" : "dma_dat_r", a_dat[m], slave_dat);
                end
                if (live) begin
                    check_output("sdr_adr", sdr_if.adr, m_adr[mi]);
                    check_output("sdr_dat_w", sdr_if.dat_w, m_dat[mi]);
                    check_output("sdr_sel", 32'(sdr_if.sel), 32'(m_sel[mi]));
                    check_output("sdr_we", 32'(sdr_if.we), 32'(m_we[mi]));
                    check_output("sdr_cti", 32'(sdr_if.cti), 32'(m_cti[mi]));
                end
            end
            // Advance the model to the state after the coming rising edge.
            if (rst) begin
                exp_owner    = 0;
                exp_abort    = 1'b0;
                exp_prio_dma = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
                exp_wait     = 0;
`endif
            end else if (exp_abort) begin
                exp_abort = 1'b0;
                exp_owner = 0;
            end else if (exp_owner == 0) begin
                if (m_cyc[0] && m_cyc[1]) winner = (dma_urgent || exp_prio_dma) ? 2 : 1;
                else if (m_cyc[1])        winner = 2;
                else if (m_cyc[0])        winner = 1;
                else                      winner = 0;
                if (winner != 0) begin
                    exp_owner    = winner;
                    exp_prio_dma = (winner == 1);
`ifdef WB_ARB_TIMEOUT_EN
                    exp_wait     = 0;
`endif
                end
            end else if (!m_cyc[mi]) begin
                exp_owner = 0;
            end else begin
`ifdef WB_ARB_TIMEOUT_EN
                if (!s_ack && exp_wait == TIMEOUT - 1) exp_abort = 1'b1;
                if (s_ack)                             exp_wait = 0;
                else if (m_stb[mi] && exp_wait < 65535) exp_wait = exp_wait + 1;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit m_active [2];
    int m_beats  [2];

    task automatic drop_master(input int idx);
        m_cyc[idx]    = 1'b0;
        m_stb[idx]    = 1'b0;
        m_active[idx] = 1'b0;
    endtask

    task automatic request(input int idx, input logic [31:0] adr);
        m_cyc[idx] = 1'b1;
        m_stb[idx] = 1'b1;
        m_we[idx]  = 1'b0;
        m_adr[idx] = adr;
        m_sel[idx] = 4'hF;
        m_dat[idx] = 32'h0;
    endtask

    task automatic new_beat(input int idx);
        m_adr[idx] = $urandom;
        m_dat[idx] = $urandom;
        m_sel[idx] = 4'($urandom);
        m_we[idx]  = 1'($urandom);
        m_stb[idx] = ($urandom % 4) != 0;
    endtask

    task automatic master_step(input int idx, input logic ack, input logic err, input logic rst_s);
        if (rst_s) begin
            drop_master(idx);
        end else if (m_active[idx]) begin
            if (err) begin
                drop_master(idx);
            end else if (ack) begin
                m_beats[idx]--;
                if (m_beats[idx] == 0) drop_master(idx);
                else                   new_beat(idx);
            end else if (!m_stb[idx]) begin
                m_stb[idx] = 1'b1;
            end
        end else if ($urandom % 3 == 0) begin
            m_active[idx] = 1'b1;
            m_beats[idx]  = $urandom_range(1, 8);
            m_cyc[idx]    = 1'b1;
            new_beat(idx);
            m_stb[idx]    = 1'b1;
        end
    endtask

    task automatic do_reset();
        drop_master(0);
        drop_master(1);
        dma_urgent  = 1'b0;
        slave_err   = 1'b0;
        slave_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic apply_stimulus();
        logic s_ack_v [2];
        logic s_err_v [2];
        logic s_rst;
        int   hang_left = 0;
        for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                s_ack_v[m] = a_ack[m];
                s_err_v[m] = a_err[m];
            end
            s_rst = rst;
            tick();
            rst        = ($urandom % 400) == 0;
            dma_urgent = ($urandom % 3) == 0;
            slave_dat  = $urandom;
            slave_err  = ($urandom % 60) == 0;
            if (hang_left > 0) begin
                hang_left--;
                slave_ready = 1'b0;
            end else begin
                if ($urandom % 64 == 0) hang_left = $urandom_range(5, 25);
                slave_ready = ($urandom % 4) != 0;
            end
            master_step(0, s_ack_v[0], s_err_v[0], s_rst);
            master_step(1, s_ack_v[1], s_err_v[1], s_rst);
        end
    endtask

    int acks;

    initial begin
        m_cti[0] = 3'b000;
        m_cti[1] = 3'b010;
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
            m_adr[m] = '0;   m_dat[m] = '0;   m_sel[m] = '0;
            m_active[m] = 1'b0; m_beats[m] = 0;
        end
        @(posedge clk);
        #1;
        check_en = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_output("rst_grant", 32'(grant), 32'h0);
        check_output("rst_sdr_cyc", 32'(sdr_if.cyc), 32'h0);
        check_output("rst_cpu_err", 32'(cpu_if.err), 32'h0);

        // Lone CPU single read
        do_reset();
        slave_ready = 1'b1;
        request(0, 32'h0000_0100);
        @(negedge clk);
        check_output("single_pre_grant", 32'(grant), 32'h0);
        tick();
        @(negedge clk);
        check_output("single_grant", 32'(grant), 32'h1);
        check_output("single_cpu_ack", 32'(cpu_if.ack), 32'h1);
        check_output("single_sdr_adr", sdr_if.adr, 32'h0000_0100);
        tick();
        drop_master(0);
        @(negedge clk);
        check_output("single_release_grant", 32'(grant), 32'h1);
        tick();
        @(negedge clk);
        check_output("single_idle_grant", 32'(grant), 32'h0);

        // Simultaneous requests from reset, round-robin hand-over
        do_reset();
        request(0, 32'h0000_0200);
        request(1, 32'h0000_0300);
        tick();
        @(negedge clk);
        check_output("rr_first_dma", 32'(grant), 32'h2);
        tick();
        drop_master(1);
        @(negedge clk);
        check_output("rr_dma_release", 32'(grant), 32'h2);
        tick();
        @(negedge clk);
        check_output("rr_dead_cycle", 32'(grant), 32'h0);
        tick();
        @(negedge clk);
        check_output("rr_then_cpu", 32'(grant), 32'h1);
        tick();
        drop_master(0);
        tick();
        tick();

        // CPU 8-beat burst is not preempted by an urgent DMA
        do_reset();
        slave_ready = 1'b1;
        request(0, 32'h0000_1000);
        m_cti[0] = 3'b010;
        tick();
        request(1, 32'h0000_2000);
        dma_urgent = 1'b1;
        acks = 0;
        for (int k = 0; k < 12 && acks < 8; k++) begin
            @(negedge clk);
            if (cpu_if.ack) acks++;
            check_output("burst_grant_cpu", 32'(grant), 32'h1);
            tick();
            if (acks == 8) drop_master(0);
        end
        check_output("burst_ack_count", 32'(acks), 32'd8);
        m_cti[0] = 3'b000;
        @(negedge clk);
        check_output("burst_release_grant", 32'(grant), 32'h1);
        tick();
        @(negedge clk);
        check_output("burst_dead_cycle", 32'(grant), 32'h0);
        tick();
        @(negedge clk);
        check_output("burst_dma_granted", 32'(grant), 32'h2);
        tick();
        drop_master(1);
        dma_urgent = 1'b0;
        tick();
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never acks: abort after TIMEOUT cycles, then the waiting DMA gets the bus
        do_reset();
        request(0, 32'h0000_0400);
        tick();
        request(1, 32'h0000_0500);
        @(negedge clk);
        check_output("to_grant_cpu", 32'(grant), 32'h1);
        repeat (15) tick();
        @(negedge clk);
        check_output("to_before_cyc", 32'(sdr_if.cyc), 32'h1);
        check_output("to_before_err", 32'(cpu_if.err), 32'h0);
        tick();
        @(negedge clk);
        check_output("to_abort_cyc", 32'(sdr_if.cyc), 32'h0);
        check_output("to_abort_err", 32'(cpu_if.err), 32'h1);
        check_output("to_abort_ack", 32'(cpu_if.ack), 32'h0);
        check_output("to_abort_dma_err", 32'(dma_if.err), 32'h0);
        tick();
        drop_master(0);
        @(negedge clk);
        check_output("to_after_err", 32'(cpu_if.err), 32'h0);
        check_output("to_after_grant", 32'(grant), 32'h0);
        tick();
        @(negedge clk);
        check_output("to_dma_granted", 32'(grant), 32'h2);
        tick();
        drop_master(1);
        tick();
        tick();

        // Ack arrives on the last allowed cycle: tenure survives
        do_reset();
        request(0, 32'h0000_0600);
        tick();
        repeat (15) tick();
        slave_ready = 1'b1;
        @(negedge clk);
        check_output("late_ack", 32'(cpu_if.ack), 32'h1);
        check_output("late_ack_err", 32'(cpu_if.err), 32'h0);
        tick();
        slave_ready = 1'b0;
        @(negedge clk);
        check_output("late_ack_cyc", 32'(sdr_if.cyc), 32'h1);
        check_output("late_ack_no_err", 32'(cpu_if.err), 32'h0);
        check_output("late_ack_grant", 32'(grant), 32'h1);
        tick();
        drop_master(0);
        tick();
        tick();
`else
        // Hung slave: grant is held indefinitely and no error is invented
        do_reset();
        request(0, 32'h0000_0600);
        repeat (40) tick();
        @(negedge clk);
        check_output("hung_grant", 32'(grant), 32'h1);
        check_output("hung_cyc", 32'(sdr_if.cyc), 32'h1);
        check_output("hung_err", 32'(cpu_if.err), 32'h0);
        tick();
        drop_master(0);
        tick();
        tick();
`endif

        // Reset during a DMA burst abandons it silently
        do_reset();
        slave_ready = 1'b1;
        request(1, 32'h0000_0700);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_mid_grant_before", 32'(grant), 32'h2);
        tick();
        rst = 1'b0;
        drop_master(1);
        @(negedge clk);
        check_output("rst_mid_grant", 32'(grant), 32'h0);
        check_output("rst_mid_cyc", 32'(sdr_if.cyc), 32'h0);
        check_output("rst_mid_cpu_err", 32'(cpu_if.err), 32'h0);
        check_output("rst_mid_dma_err", 32'(dma_if.err), 32'h0);

        // Randomized traffic against the model
        apply_stimulus();
        tick();
        rst = 1'b0;
        drop_master(0);
        drop_master(1);
        slave_ready = 1'b1;
        slave_err   = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check_output("final_idle_grant", 32'(grant), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_sdram_arbiter.md
WB_SDRAM_ARBITER -- requirements
Module: wb_sdram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1024: cycles a granted strobe may wait for ack before abort; range 16..65535.
REQ-002 Parameter DMA_FIRST, default 1: tie-break winner from reset (1 = DMA, 0 = CPU).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cpu_bus  wishbone_b3 slave modport  --  processor requester.
REQ-006 dma_bus  wishbone_b3 slave modport  --  screen DMA requester.
REQ-007 sdr_bus  wishbone_b3 master modport  --  shared SDRAM controller port.
REQ-008 dma_urgent  input  1  DMA line buffer below refill threshold; level-sensitive.
REQ-009 grant  output  2  one-hot current owner, {dma, cpu}; 2'b00 when idle.

Function
REQ-010 FSM states: IDLE, GNT_CPU, GNT_DMA, ABORT; registered state, single clk domain.
REQ-011 IDLE, exactly one cyc high: go to that master's GNT state next cycle.
REQ-012 IDLE, both cyc high: DMA wins if dma_urgent; else the master not granted last (round-robin); first arbitration after reset uses DMA_FIRST.
REQ-013 Grant latency: request sampled in IDLE at cycle N; sdr_bus driven from winner starting cycle N+1.
REQ-014 Granted: sdr_bus adr/dat/sel/we/cyc/stb/cti/bte = winner's signals combinationally; winner's ack/err/dat_i = sdr_bus's.
REQ-015 Non-granted master: ack=0, err=0; its dat_i = sdr_bus dat (don't-care).
REQ-016 No preemption: tenure lasts while the granted master holds cyc, including multi-beat bursts; dma_urgent never interrupts a CPU tenure.
REQ-017 Release: granted cyc low at cycle M -> IDLE at M+1 with sdr_bus cyc/stb=0; earliest new grant at M+2 (one dead cycle between tenures, always).
REQ-018 Wait counter: 16 bits; clears on grant entry and on each ack; increments each cycle with granted stb=1 and ack=0; saturates, never wraps.
REQ-019 Counter == TIMEOUT-1 with no ack: go to ABORT.
REQ-020 ABORT (one cycle): sdr_bus cyc/stb=0; err=1 to the owner for exactly that cycle; ack to it forced 0; then IDLE.
REQ-021 ack and timeout in the same cycle: ack wins, counter clears, no abort.
REQ-022 grant output registered; equals the FSM state decode.

Reset
REQ-023 rst high at a clk edge: state=IDLE, grant=00, counter=0, last-owner=DMA_FIRST; sdr_bus cyc/stb=0 and all master ack/err=0 from the following cycle.
REQ-024 rst mid-tenure abandons the transfer silently (no err); masters are reset by the same rst.

Configuration
REQ-025 Macro WB_ARB_TIMEOUT_EN: when defined, REQ-018..REQ-021 and state ABORT are present.
REQ-026 Without WB_ARB_TIMEOUT_EN: no counter, no ABORT state; err passes through from sdr_bus only; a hung slave holds the grant indefinitely.

Structure
REQ-027 Package wb_arb_pkg holds the state enum typedef, the grant one-hot typedef, and the GRANT_NONE/GRANT_CPU/GRANT_DMA constants.
REQ-028 No sub-module; the mux, FSM and counter are a single module.
REQ-029 Top level instantiates the arbiter between ThermoProcessor's sdr_bus, screen_dma's bus and wb_sdram16.

Verification
REQ-030 CPU single read of 0x0000_0100 alone -> grant=01 one cycle after cyc; slave ack returned to CPU; grant=00 one cycle after CPU drops cyc.
REQ-031 Both request same cycle from reset, dma_urgent=0, DMA_FIRST=1 -> DMA granted; DMA releases; both still requesting -> CPU granted after one dead cycle.
REQ-032 CPU 8-beat burst in progress, DMA asserts cyc with dma_urgent=1 -> all 8 CPU acks complete with no preemption; DMA granted 2 cycles after CPU cyc falls.
REQ-033 With WB_ARB_TIMEOUT_EN and TIMEOUT=16, slave never acks the CPU -> sdr_bus cyc drops and CPU sees err=1 for exactly one cycle 16 cycles after the grant; then the pending DMA is granted.
REQ-034 Slave acks on the same cycle the counter reaches 15 (TIMEOUT=16) -> normal ack, no err, tenure continues.
REQ-035 rst asserted during a DMA burst -> the next cycle shows grant=00, sdr_bus cyc=0, no err to either master.
